thermo_check_arbiter: RTL and testbench

- Shares one thermometer-code detector among NUM_REQ requesters.
- A round-robin arbiter grants one requester per cycle and evaluates its code combinationally.
- The result, tagged with the requester id, is registered into a single-entry output stage with valid/ready handshake.
- Saturating statistics counters and an enable/drain state machine support sequencing by a higher-level controller.

---
 rtl/thermo_check_arbiter_pkg.sv | 25 ++
 rtl/thermo_check_arbiter_rr_arbiter.sv | 31 +++
 rtl/thermo_check_arbiter.sv | 135 +++++++++++++
 tb/tb_thermo_check_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/thermo_check_arbiter_pkg.sv
// Shared types and the thermometer-code rule for the arbitrated code checker.
package thermo_pkg;

   localparam int unsigned THERMO_MAX_W    = 64;
   localparam int unsigned NUM_REQ_DEFAULT = 4;
   localparam int unsigned ID_W            = $clog2(NUM_REQ_DEFAULT);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_e;

   // Exactly one differing adjacent pair over the low 'width' bits.
   function automatic logic is_thermo(input logic [THERMO_MAX_W-1:0] code,
                                      input int unsigned             width);
      int unsigned edges;
      edges = 0;
      for (int unsigned i = 0; i < THERMO_MAX_W - 1; i++) begin
         if ((i + 1 < width) && (code[i] ^ code[i+1])) edges++;
      end
      return edges == 1;
   endfunction

endpackage

// File: rtl/thermo_check_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or above ptr_i, wrapping.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic          enable_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   logic        found;
   int unsigned slot;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      slot  = 0;
      for (int unsigned k = 0; k < N; k++) begin
         slot = (32'(ptr_i) + k) % N;
         if (enable_i && !found && req_i[slot]) begin
            found       = 1'b1;
            gnt_o[slot] = 1'b1;
            idx_o       = IW'(slot);
         end
      end
   end

endmodule

// File: rtl/thermo_check_arbiter.sv
// Shares one thermometer-code checker among NUM_REQ requesters behind a
// round-robin grant, a one-entry valid/ready result stage and saturating stats.
module thermo_check_arbiter
   import thermo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_code,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic [$clog2(NUM_REQ)-1:0]    resp_id,
   output logic [DATA_WIDTH-1:0]         resp_code,
   output logic                          resp_is_thermo,
   output logic                          busy,
   output logic [CNT_WIDTH-1:0]          cnt_total,
   output logic [CNT_WIDTH-1:0]          cnt_thermo
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   state_e                  state_q, state_d;
   logic [IW-1:0]           ptr_q, ptr_d;
   logic                    valid_q, valid_d;
   logic [IW-1:0]           id_q, id_d;
   logic [DATA_WIDTH-1:0]   code_q, code_d;
   logic                    thermo_q, thermo_d;
   logic [CNT_WIDTH-1:0]    tot_q, tot_d;
   logic [CNT_WIDTH-1:0]    th_q, th_d;

   logic                    slot_free;
   logic                    grant_en;
   logic [NUM_REQ-1:0]      gnt;
   logic [IW-1:0]           win_idx;
   logic [DATA_WIDTH-1:0]   win_code;
   logic [THERMO_MAX_W-1:0] code_ext;
   logic                    win_thermo;
   logic                    xfer;

   assign slot_free = !valid_q || resp_ready;
   // en is checked directly so the cycle that leaves RUN never grants.
   assign grant_en  = (state_q == RUN) && en && slot_free;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_arb (
      .req_i    (req_valid),
      .ptr_i    (ptr_q),
      .enable_i (grant_en),
      .gnt_o    (gnt),
      .idx_o    (win_idx)
   );

   assign xfer     = |gnt;
   assign win_code = req_code[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      code_ext                 = '0;
      code_ext[DATA_WIDTH-1:0] = win_code;
      win_thermo               = is_thermo(code_ext, DATA_WIDTH);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (en) state_d = RUN;
         RUN:     if (!en) state_d = DRAIN;
         DRAIN: begin
            if (en)            state_d = RUN;
            else if (!valid_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ptr_d    = ptr_q;
      valid_d  = valid_q;
      id_d     = id_q;
      code_d   = code_q;
      thermo_d = thermo_q;
      tot_d    = tot_q;
      th_d     = th_q;
      if (xfer) begin
         valid_d  = 1'b1;
         id_d     = win_idx;
         code_d   = win_code;
         thermo_d = win_thermo;
         ptr_d    = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
         if (tot_q != '1) tot_d = tot_q + CNT_WIDTH'(1);
         if (win_thermo && (th_q != '1)) th_d = th_q + CNT_WIDTH'(1);
      end else if (resp_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         valid_q  <= 1'b0;
         id_q     <= '0;
         code_q   <= '0;
         thermo_q <= 1'b0;
         tot_q    <= '0;
         th_q     <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         valid_q  <= valid_d;
         id_q     <= id_d;
         code_q   <= code_d;
         thermo_q <= thermo_d;
         tot_q    <= tot_d;
         th_q     <= th_d;
      end
   end

   assign req_ready      = gnt;
   assign resp_valid     = valid_q;
   assign resp_id        = id_q;
   assign resp_code      = code_q;
   assign resp_is_thermo = thermo_q;
   assign busy           = (state_q != IDLE) || valid_q;
   assign cnt_total      = tot_q;
   assign cnt_thermo     = th_q;

endmodule

// File: tb/tb_thermo_check_arbiter.sv
// Directed bench with a reference model and response scoreboard.
module tb_thermo_check_arbiter;

   localparam int unsigned DW = 8;
   localparam int unsigned NR = 4;
   localparam int unsigned CW = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             en;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_code;
   logic [NR-1:0]    req_ready;
   logic             resp_valid;
   logic             resp_ready;
   logic [1:0]       resp_id;
   logic [DW-1:0]    resp_code;
   logic             resp_is_thermo;
   logic             busy;
   logic [CW-1:0]    cnt_total;
   logic [CW-1:0]    cnt_thermo;

   thermo_check_arbiter #(
      .DATA_WIDTH (DW),
      .NUM_REQ    (NR),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .en             (en),
      .req_valid      (req_valid),
      .req_code       (req_code),
      .req_ready      (req_ready),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_id        (resp_id),
      .resp_code      (resp_code),
      .resp_is_thermo (resp_is_thermo),
      .busy           (busy),
      .cnt_total      (cnt_total),
      .cnt_thermo     (cnt_thermo)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] code;
      logic       th;
   } resp_t;

   resp_t      sb[$];
   int         total = 0;
   int         bad   = 0;
   int         m_state;
   logic [1:0] m_ptr;
   logic       m_valid;
   logic [3:0] m_tot;
   logic [3:0] m_th;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Thermometer codes are exactly the masks of k low ones (or their inverse), 0<k<8.
   function automatic logic m_is_thermo(input logic [7:0] c);
      logic [7:0] m;
      for (int k = 1; k < 8; k++) begin
         m = (8'h01 << k) - 8'h01;
         if (c == m || c == ~m) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic set_code(input int unsigned r, input logic [7:0] c);
      req_code[r*DW +: DW] = c;
   endtask

   task automatic model_reset();
      m_state = 0;
      m_ptr   = '0;
      m_valid = 1'b0;
      m_tot   = '0;
      m_th    = '0;
      sb.delete();
   endtask

   // Called at posedge+1 with inputs already driven; returns at next posedge+1.
   task automatic cycle();
      logic [3:0] eg;
      logic [1:0] ei;
      logic       xfer;
      logic       v_now;
      resp_t      e;
      #3;
      eg   = '0;
      ei   = '0;
      xfer = 1'b0;
      if (m_state == 1 && en && (!m_valid || resp_ready)) begin
         for (int k = 0; k < NR; k++) begin
            int j;
            j = (int'(m_ptr) + k) % NR;
            if (!xfer && req_valid[j]) begin
               xfer  = 1'b1;
               eg[j] = 1'b1;
               ei    = 2'(j);
            end
         end
      end
      chk("req_ready", req_ready, eg);
      chk("resp_valid", resp_valid, m_valid);
      chk("busy", busy, (m_state != 0) || m_valid);
      if (m_valid && sb.size() != 0) begin
         chk("resp_id", resp_id, sb[0].id);
         chk("resp_code", resp_code, sb[0].code);
         chk("resp_is_thermo", resp_is_thermo, sb[0].th);
         if (resp_ready) void'(sb.pop_front());
      end
      v_now = m_valid;
      if (xfer) begin
         e.id   = ei;
         e.code = req_code[ei*DW +: DW];
         e.th   = m_is_thermo(e.code);
         sb.push_back(e);
         m_ptr = (ei == 2'(NR - 1)) ? 2'd0 : ei + 2'd1;
         if (m_tot != 4'hF) m_tot++;
         if (e.th && m_th != 4'hF) m_th++;
         m_valid = 1'b1;
      end else if (resp_ready) begin
         m_valid = 1'b0;
      end
      case (m_state)
         0: if (en) m_state = 1;
         1: if (!en) m_state = 2;
         default: begin
            if (en) m_state = 1;
            else if (!v_now) m_state = 0;
         end
      endcase
      @(posedge clk);
      #1;
      chk("cnt_total", cnt_total, m_tot);
      chk("cnt_thermo", cnt_thermo, m_th);
   endtask

   logic [7:0] nt_code [4];
   logic       nt_exp  [4];

   initial begin
      nt_code = '{8'h00, 8'hFF, 8'h2F, 8'hE0};
      nt_exp  = '{1'b0, 1'b0, 1'b0, 1'b1};

      reset      = 1'b1;
      en         = 1'b0;
      req_valid  = '0;
      req_code   = '0;
      resp_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_req_ready", req_ready, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cnt_total", cnt_total, 4'd0);
      chk("rst_cnt_thermo", cnt_thermo, 4'd0);
      reset = 1'b0;
      model_reset();

      // Single request from requester 2
      en = 1'b1;
      cycle();
      req_valid  = 4'b0100;
      resp_ready = 1'b1;
      set_code(2, 8'b0001_1111);
      #1;
      chk("single_gnt", req_ready, 4'b0100);
      cycle();
      req_valid = '0;
      chk("single_valid", resp_valid, 1'b1);
      chk("single_id", resp_id, 2'd2);
      chk("single_thermo", resp_is_thermo, 1'b1);
      chk("single_cnt_total", cnt_total, 4'd1);
      chk("single_cnt_thermo", cnt_thermo, 4'd1);

      // Code classification through requester 3 (pointer ends at 0)
      for (int i = 0; i < 4; i++) begin
         req_valid = 4'b1000;
         set_code(3, nt_code[i]);
         cycle();
         req_valid = '0;
         chk("class_thermo", resp_is_thermo, nt_exp[i]);
      end
      cycle();

      // Fairness with all requesters active
      set_code(0, 8'h0F);
      set_code(1, 8'h3C);
      set_code(2, 8'hF0);
      set_code(3, 8'h01);
      req_valid = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("fair_gnt", req_ready, 4'b0001 << (i % 4));
         cycle();
         chk("fair_tput", resp_valid, 1'b1);
      end

      // Backpressure holds the pending result and blocks grants
      resp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("bp_hold_id", resp_id, 2'd1);
      end
      resp_ready = 1'b1;
      #1;
      chk("bp_release_gnt", req_ready, 4'b0100);
      cycle();

      // Drain with a pending result
      en         = 1'b0;
      resp_ready = 1'b0;
      cycle();
      cycle();
      cycle();
      chk("drain_busy", busy, 1'b1);
      chk("drain_pending", resp_valid, 1'b1);
      resp_ready = 1'b1;
      cycle();
      cycle();
      cycle();
      chk("drain_idle_busy", busy, 1'b0);

      // Counter saturation
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      set_code(0, 8'h07);
      set_code(1, 8'h1F);
      set_code(2, 8'h7F);
      set_code(3, 8'hFE);
      en = 1'b1;
      cycle();
      req_valid = 4'b1111;
      for (int i = 0; i < 20; i++) cycle();
      chk("sat_total", cnt_total, 4'hF);
      chk("sat_thermo", cnt_thermo, 4'hF);
      chk("sat_stream_valid", resp_valid, 1'b1);

      // Asynchronous reset in mid-stream
      reset = 1'b1;
      #2;
      chk("arst_resp_valid", resp_valid, 1'b0);
      chk("arst_cnt_total", cnt_total, 4'd0);
      chk("arst_cnt_thermo", cnt_thermo, 4'd0);
      chk("arst_req_ready", req_ready, 4'b0000);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      req_valid = '0;
      model_reset();
      for (int i = 0; i < 3; i++) cycle();
      chk("arst_lost", resp_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
